// File: rtl/ahb_pwm_capture.sv
// ahb_pwm_capture: AHB-slave period/high-time capture on 4 PWM inputs, counted in I_ahb_clk cycles.
// Define PWM_CAPTURE_IRQ_EN to add the masked O_irq output and CTRL[11:8] irq_mask.
module ahb_pwm_capture #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        I_ahb_clk,
  input  logic        I_rst,
  input  logic [1:0]  I_ahb_htrans,
  input  logic        I_ahb_hwrite,
  input  logic [31:0] I_ahb_haddr,
  input  logic [2:0]  I_ahb_hsize,
  input  logic [2:0]  I_ahb_hburst,
  input  logic [3:0]  I_ahb_hprot,
  input  logic        I_ahb_hmastlock,
  input  logic [31:0] I_ahb_hwdata,
  output logic [31:0] O_ahb_hrdata,
  output logic [1:0]  O_ahb_hresp,
  output logic        O_ahb_hready,
`ifdef PWM_CAPTURE_IRQ_EN
  output logic        O_irq,
`endif
  input  logic [3:0]  I_cap
);
  typedef enum logic [1:0] {B_IDLE, B_ADDR, B_DATA} bus_e;
  typedef enum logic [1:0] {C_IDLE, C_ARM, C_RUN} ch_e;
  bus_e bst_q, bst_d;
  ch_e [3:0] st_q, st_d;
  logic write_q, wr_commit, rd_commit, ctrl_w, stat_w, cap_sel, unused_ok;
  logic [7:0] addr_q;
  logic [11:0] wdata_q;
  logic [31:0] hrdata_q, ctrl_rd, rd_data;
  logic [1:0] ch;
  logic [3:0] en_q, en_d, valid_q, valid_d, ovf_q, ovf_d, vset, oset;
  logic [3:0] lvl, prev_q, rise, fall, run, sat;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d, hold_q, hold_d, per_q, per_d, high_q, high_d;
  assign unused_ok = ^{I_ahb_hsize, I_ahb_hburst, I_ahb_hprot, I_ahb_hmastlock,
                       I_ahb_haddr[31:8], I_ahb_hwdata[31:12], wdata_q};
  always_ff @(posedge I_ahb_clk or posedge I_rst)
    if (I_rst) bst_q <= B_IDLE;
    else bst_q <= bst_d;
  always_comb
    bst_d = bst_q == B_IDLE ? (I_ahb_htrans == 2'b10 ? B_ADDR : B_IDLE)
          : bst_q == B_ADDR ? B_DATA : B_IDLE;
  always_comb begin
    O_ahb_hready = bst_q == B_IDLE;
    wr_commit    = bst_q == B_DATA && write_q;
    rd_commit    = bst_q == B_DATA && !write_q;
  end
  assign O_ahb_hresp  = 2'b00;
  assign O_ahb_hrdata = hrdata_q;
  assign ctrl_w = wr_commit && addr_q == 8'h00;
  assign stat_w = wr_commit && addr_q == 8'h04;
  always_ff @(posedge I_ahb_clk or posedge I_rst)
    if (I_rst) begin
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hrdata_q <= '0;
    end else begin
      if (bst_q == B_IDLE && I_ahb_htrans == 2'b10) write_q <= I_ahb_hwrite;
      if (bst_q == B_ADDR) begin
        addr_q  <= I_ahb_haddr[7:0];
        wdata_q <= I_ahb_hwdata[11:0];
      end
      if (rd_commit) hrdata_q <= rd_data;
    end
  // Hardware set is OR-ed in after the W1C mask so a same-cycle event wins.
  always_comb begin
    en_d    = ctrl_w ? wdata_q[3:0] : en_q;
    valid_d = (valid_q & ~(stat_w ? wdata_q[3:0] : 4'h0)) | vset;
    ovf_d   = (ovf_q & ~(stat_w ? wdata_q[7:4] : 4'h0)) | oset;
  end
  assign ch      = 2'(addr_q[7:3] - 5'd1);
  assign cap_sel = addr_q[1:0] == 2'b00 && addr_q >= 8'h08 && addr_q <= 8'h24;
  assign rd_data = addr_q == 8'h00 ? ctrl_rd
                 : addr_q == 8'h04 ? {24'h0, ovf_q, valid_q}
                 : !cap_sel ? '0
                 : addr_q[2] ? 32'(high_q[ch]) : 32'(per_q[ch]);
  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;
  always_ff @(posedge I_ahb_clk or posedge I_rst)
    if (I_rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      en_q    <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      per_q   <= '0;
      high_q  <= '0;
      for (int i = 0; i < 4; i++) st_q[i] <= C_IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], I_cap};
      prev_q  <= lvl;
      en_q    <= en_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      per_q   <= per_d;
      high_q  <= high_d;
      st_q    <= st_d;
    end
  always_comb begin
    st_d = st_q;
    for (int i = 0; i < 4; i++)
      st_d[i] = !en_q[i] ? C_IDLE
              : st_q[i] == C_IDLE ? C_ARM
              : st_q[i] == C_ARM && rise[i] ? C_RUN : st_q[i];
  end
  always_comb begin
    run = '0;
    sat = '0;
    for (int i = 0; i < 4; i++) begin
      run[i] = en_q[i] && st_q[i] == C_RUN;
      sat[i] = cnt_q[i] == {CNT_W{1'b1}};
    end
  end
  // A rise on a saturated count only restarts the period; the stale measurement is dropped.
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    per_d  = per_q;
    high_d = high_q;
    vset   = '0;
    oset   = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]  = (run[i] || (en_q[i] && st_q[i] == C_ARM)) && rise[i] ? CNT_W'(1)
                : !run[i] ? '0 : sat[i] ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      hold_d[i] = run[i] && fall[i] ? cnt_q[i] : hold_q[i];
      vset[i]   = run[i] && rise[i] && !sat[i];
      oset[i]   = run[i] && sat[i];
      per_d[i]  = vset[i] ? cnt_q[i] : per_q[i];
      high_d[i] = vset[i] ? hold_q[i] : high_q[i];
    end
  end
`ifdef PWM_CAPTURE_IRQ_EN
  logic [3:0] mask_q;
  logic irq_q;
  always_ff @(posedge I_ahb_clk or posedge I_rst)
    if (I_rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_w) mask_q <= wdata_q[11:8];
      irq_q <= |(valid_q & mask_q);
    end
  assign O_irq   = irq_q;
  assign ctrl_rd = {20'h0, mask_q, 4'h0, en_q};
`else
  assign ctrl_rd = {28'h0, en_q};
`endif
endmodule
